// File: rtl/atm.sv
// ATM transaction controller: 16-account PIN/balance table, login with lockout,
// and balance, deposit, withdraw and PIN-change sessions driven by a front panel.
module atm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  operation,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] Newpin,
    input  logic [15:0] amount,
    input  logic        language,
    output logic [15:0] balance,
    output logic [2:0]  current_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        AUTH       = 3'd1,
        MENU       = 3'd2,
        BALANCE    = 3'd3,
        DEPOSIT    = 3'd4,
        WITHDRAW   = 3'd5,
        CHANGE_PIN = 3'd6,
        ERROR      = 3'd7
    } state_t;

    localparam logic [2:0] OP_NONE       = 3'd0;
    localparam logic [2:0] OP_BALANCE    = 3'd1;
    localparam logic [2:0] OP_DEPOSIT    = 3'd2;
    localparam logic [2:0] OP_WITHDRAW   = 3'd3;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
    localparam logic [2:0] OP_LOGOUT     = 3'd5;

    state_t      state;
    logic [15:0] pin_table [16];
    logic [15:0] bal_table [16];
    logic [1:0]  fail_cnt  [16];
    logic [15:0] locked;
    logic [3:0]  acc_q;
    logic [15:0] pin_q;
    logic        session_lang;
    logic        session_open;
    logic        armed;

    logic [15:0] cur_bal;
    logic [16:0] dep_sum;
    logic        unused_ok;

    assign cur_bal       = bal_table[acc_q];
    assign dep_sum       = {1'b0, cur_bal} + {1'b0, amount};
    assign current_state = state;
    // The session language only selects display text in the front panel.
    assign unused_ok     = session_lang;

    // NOTE: every register here uses non-blocking assignments so all updates
    // land together on the clock edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            balance      <= 16'd0;
            acc_q        <= 4'd0;
            pin_q        <= 16'd0;
            session_lang <= 1'b0;
            session_open <= 1'b0;
            armed        <= 1'b0;
            locked       <= 16'd0;
            // NOTE: the account table is reset on purpose: each account must come
            // back with its factory PIN and balance, so it is built from flops, not RAM.
            for (int i = 0; i < 16; i++) begin
                pin_table[i] <= 16'(1000 + i);
                bal_table[i] <= 16'd1000;
                fail_cnt[i]  <= 2'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (operation != OP_NONE) begin
                        acc_q        <= acc_num;
                        pin_q        <= pin;
                        session_lang <= language;
                        state        <= AUTH;
                    end
                end
                AUTH: begin
                    if (locked[acc_q]) begin
                        state <= ERROR;
                    end else if (pin_q == pin_table[acc_q]) begin
                        fail_cnt[acc_q] <= 2'd0;
                        session_open    <= 1'b1;
                        armed           <= 1'b0;
                        balance         <= cur_bal;
                        state           <= MENU;
                    end else begin
                        if (fail_cnt[acc_q] != 2'd3)
                            fail_cnt[acc_q] <= fail_cnt[acc_q] + 2'd1;
                        if (fail_cnt[acc_q] == 2'd2)
                            locked[acc_q] <= 1'b1;
                        state <= ERROR;
                    end
                end
                MENU: begin
                    // A held request must drop to NONE before the next dispatch.
                    if (!armed) begin
                        if (operation == OP_NONE)
                            armed <= 1'b1;
                    end else begin
                        case (operation)
                            OP_BALANCE:    begin armed <= 1'b0; state <= BALANCE;    end
                            OP_DEPOSIT:    begin armed <= 1'b0; state <= DEPOSIT;    end
                            OP_WITHDRAW:   begin armed <= 1'b0; state <= WITHDRAW;   end
                            OP_CHANGE_PIN: begin armed <= 1'b0; state <= CHANGE_PIN; end
                            OP_LOGOUT: begin
                                armed        <= 1'b0;
                                session_open <= 1'b0;
                                balance      <= 16'd0;
                                state        <= IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                BALANCE: begin
                    balance <= cur_bal;
                    state   <= MENU;
                end
                DEPOSIT: begin
                    if (dep_sum[16]) begin
                        balance <= cur_bal;
                        state   <= ERROR;
                    end else begin
                        bal_table[acc_q] <= dep_sum[15:0];
                        balance          <= dep_sum[15:0];
                        state            <= MENU;
                    end
                end
                WITHDRAW: begin
                    if (amount > cur_bal) begin
                        balance <= cur_bal;
                        state   <= ERROR;
                    end else begin
                        bal_table[acc_q] <= cur_bal - amount;
                        balance          <= cur_bal - amount;
                        state            <= MENU;
                    end
                end
                CHANGE_PIN: begin
                    pin_table[acc_q] <= Newpin;
                    balance          <= cur_bal;
                    state            <= MENU;
                end
                ERROR: begin
                    if (session_open) begin
                        armed   <= 1'b0;
                        balance <= cur_bal;
                        state   <= MENU;
                    end else begin
                        balance <= 16'd0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm.sv
// Scoreboard bench for atm: the driver queues the expected state/balance for
// each cycle it drives, and a monitor pops and compares after every clock edge.
module tb_atm;

    localparam logic [2:0] S_IDLE = 3'd0, S_AUTH = 3'd1, S_MENU = 3'd2, S_BAL = 3'd3;
    localparam logic [2:0] S_DEP  = 3'd4, S_WD   = 3'd5, S_CPIN = 3'd6, S_ERR = 3'd7;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [15:0] bal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  operation = 3'd0;
    logic [3:0]  acc_num = 4'd0;
    logic [15:0] pin = 16'd0;
    logic [15:0] Newpin = 16'd0;
    logic [15:0] amount = 16'd0;
    logic        language = 1'b0;
    logic [15:0] balance;
    logic [2:0]  current_state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    atm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .operation     (operation),
        .acc_num       (acc_num),
        .pin           (pin),
        .Newpin        (Newpin),
        .amount        (amount),
        .language      (language),
        .balance       (balance),
        .current_state (current_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string name, input logic [2:0] op, input logic [3:0] acc,
                        input logic [15:0] p, input logic [15:0] np, input logic [15:0] amt,
                        input logic [2:0] st, input logic [15:0] bal);
        @(negedge clk);
        operation = op;
        acc_num   = acc;
        pin       = p;
        Newpin    = np;
        amount    = amt;
        language  = acc[0];
        exp_q.push_back('{name, st, bal});
    endtask

    // Monitor: compares the DUT outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".state"}, 16'(current_state), 16'(e.st));
                check({e.name, ".balance"}, balance, e.bal);
            end
        end
    end

    initial begin
        // Reset values while rst_n is held low.
        step("reset",       3'd0, 4'd0, 16'd0, 16'd0, 16'd0, S_IDLE, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Login account 3.
        step("idle_hold",   3'd0, 4'd3, 16'd1003, 16'd0, 16'd0, S_IDLE, 16'd0);
        step("login3",      3'd1, 4'd3, 16'd1003, 16'd0, 16'd0, S_AUTH, 16'd0);
        step("auth3",       3'd1, 4'd3, 16'd1003, 16'd0, 16'd0, S_MENU, 16'd1000);
        step("menu_unarmed",3'd1, 4'd3, 16'd0,    16'd0, 16'd0, S_MENU, 16'd1000);

        // Deposit 250, then hold the request without re-arming.
        step("arm1",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,   S_MENU, 16'd1000);
        step("dep_disp",    3'd2, 4'd3, 16'd0, 16'd0, 16'd250, S_DEP,  16'd1000);
        step("dep_done",    3'd2, 4'd3, 16'd0, 16'd0, 16'd250, S_MENU, 16'd1250);
        step("dep_hold1",   3'd2, 4'd3, 16'd0, 16'd0, 16'd250, S_MENU, 16'd1250);
        step("dep_hold2",   3'd2, 4'd3, 16'd0, 16'd0, 16'd250, S_MENU, 16'd1250);

        // Over-withdraw fails, exact withdraw empties the account.
        step("arm2",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,    S_MENU, 16'd1250);
        step("wd_big_disp", 3'd3, 4'd3, 16'd0, 16'd0, 16'd1300, S_WD,   16'd1250);
        step("wd_big_err",  3'd3, 4'd3, 16'd0, 16'd0, 16'd1300, S_ERR,  16'd1250);
        step("wd_big_menu", 3'd3, 4'd3, 16'd0, 16'd0, 16'd1300, S_MENU, 16'd1250);
        step("arm3",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,    S_MENU, 16'd1250);
        step("wd_all_disp", 3'd3, 4'd3, 16'd0, 16'd0, 16'd1250, S_WD,   16'd1250);
        step("wd_all_done", 3'd3, 4'd3, 16'd0, 16'd0, 16'd1250, S_MENU, 16'd0);

        // Ignored codes 6/7 keep MENU armed; balance inquiry follows.
        step("arm4",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0, S_MENU, 16'd0);
        step("op6_ignored", 3'd6, 4'd3, 16'd0, 16'd0, 16'd0, S_MENU, 16'd0);
        step("op7_ignored", 3'd7, 4'd3, 16'd0, 16'd0, 16'd0, S_MENU, 16'd0);
        step("bal_disp",    3'd1, 4'd3, 16'd0, 16'd0, 16'd0, S_BAL,  16'd0);
        step("bal_done",    3'd1, 4'd3, 16'd0, 16'd0, 16'd0, S_MENU, 16'd0);

        // Refill to 1000, then an overflowing deposit of 65000.
        step("arm5",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,     S_MENU, 16'd0);
        step("refill_disp", 3'd2, 4'd3, 16'd0, 16'd0, 16'd1000,  S_DEP,  16'd0);
        step("refill_done", 3'd2, 4'd3, 16'd0, 16'd0, 16'd1000,  S_MENU, 16'd1000);
        step("arm6",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,     S_MENU, 16'd1000);
        step("ovf_disp",    3'd2, 4'd3, 16'd0, 16'd0, 16'd65000, S_DEP,  16'd1000);
        step("ovf_err",     3'd2, 4'd3, 16'd0, 16'd0, 16'd65000, S_ERR,  16'd1000);
        step("ovf_menu",    3'd0, 4'd3, 16'd0, 16'd0, 16'd0,     S_MENU, 16'd1000);

        // Deposit up to exactly 65535, then withdraw back to 1000.
        step("arm7",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,     S_MENU, 16'd1000);
        step("max_disp",    3'd2, 4'd3, 16'd0, 16'd0, 16'd64535, S_DEP,  16'd1000);
        step("max_done",    3'd2, 4'd3, 16'd0, 16'd0, 16'd64535, S_MENU, 16'd65535);
        step("arm8",        3'd0, 4'd3, 16'd0, 16'd0, 16'd0,     S_MENU, 16'd65535);
        step("back_disp",   3'd3, 4'd3, 16'd0, 16'd0, 16'd64535, S_WD,   16'd65535);
        step("back_done",   3'd3, 4'd3, 16'd0, 16'd0, 16'd64535, S_MENU, 16'd1000);

        // Change PIN to 4321 and log out.
        step("arm9",        3'd0, 4'd3, 16'd0, 16'd0,    16'd0, S_MENU, 16'd1000);
        step("cpin_disp",   3'd4, 4'd3, 16'd0, 16'd4321, 16'd0, S_CPIN, 16'd1000);
        step("cpin_done",   3'd4, 4'd3, 16'd0, 16'd4321, 16'd0, S_MENU, 16'd1000);
        step("arm10",       3'd0, 4'd3, 16'd0, 16'd0,    16'd0, S_MENU, 16'd1000);
        step("logout1",     3'd5, 4'd3, 16'd0, 16'd0,    16'd0, S_IDLE, 16'd0);

        // The old PIN is rejected, the new one accepted.
        step("old_pin",     3'd1, 4'd3, 16'd1003, 16'd0, 16'd0, S_AUTH, 16'd0);
        step("old_pin_err", 3'd0, 4'd3, 16'd0,    16'd0, 16'd0, S_ERR,  16'd0);
        step("old_pin_idle",3'd0, 4'd3, 16'd0,    16'd0, 16'd0, S_IDLE, 16'd0);
        step("new_pin",     3'd1, 4'd3, 16'd4321, 16'd0, 16'd0, S_AUTH, 16'd0);
        step("new_pin_menu",3'd0, 4'd3, 16'd0,    16'd0, 16'd0, S_MENU, 16'd1000);
        step("arm11",       3'd0, 4'd3, 16'd0,    16'd0, 16'd0, S_MENU, 16'd1000);
        step("logout2",     3'd5, 4'd3, 16'd0,    16'd0, 16'd0, S_IDLE, 16'd0);

        // Three wrong PINs lock account 7; the correct PIN is then refused.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("bad%0d_auth", i), 3'd1, 4'd7, 16'd7, 16'd0, 16'd0, S_AUTH, 16'd0);
            step($sformatf("bad%0d_err", i),  3'd0, 4'd7, 16'd0, 16'd0, 16'd0, S_ERR,  16'd0);
            step($sformatf("bad%0d_idle", i), 3'd0, 4'd7, 16'd0, 16'd0, 16'd0, S_IDLE, 16'd0);
        end
        step("locked_auth", 3'd1, 4'd7, 16'd1007, 16'd0, 16'd0, S_AUTH, 16'd0);
        step("locked_err",  3'd0, 4'd7, 16'd0,    16'd0, 16'd0, S_ERR,  16'd0);
        step("locked_idle", 3'd0, 4'd7, 16'd0,    16'd0, 16'd0, S_IDLE, 16'd0);

        // Reset pulse clears the lock and restores factory PINs.
        @(negedge clk);
        rst_n = 1'b0;
        step("reset2",      3'd0, 4'd0, 16'd0, 16'd0, 16'd0, S_IDLE, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("unlock_auth", 3'd1, 4'd7, 16'd1007, 16'd0, 16'd0, S_AUTH, 16'd0);
        step("unlock_menu", 3'd0, 4'd7, 16'd0,    16'd0, 16'd0, S_MENU, 16'd1000);
        step("arm12",       3'd0, 4'd7, 16'd0,    16'd0, 16'd0, S_MENU, 16'd1000);
        step("logout3",     3'd5, 4'd7, 16'd0,    16'd0, 16'd0, S_IDLE, 16'd0);
        step("pin3_auth",   3'd1, 4'd3, 16'd1003, 16'd0, 16'd0, S_AUTH, 16'd0);
        step("pin3_menu",   3'd0, 4'd3, 16'd0,    16'd0, 16'd0, S_MENU, 16'd1000);

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/atm.md
# atm

Single-clock ATM transaction controller holding a 16-entry account table (PIN and balance per account). It authenticates a user by account number and PIN, then serves balance inquiry, deposit, withdrawal and PIN change, and reports the session balance and FSM state. It is the top-level controller of the ATM design; a front-end panel drives its request inputs.

## Interface
- No parameters; account count 16, widths fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- operation  in  3  request code: 0 none, 1 balance, 2 deposit, 3 withdraw, 4 change PIN, 5 logout, 6/7 ignored
- acc_num  in  4  account index 0..15
- pin  in  16  entered PIN
- Newpin  in  16  replacement PIN for op 4
- amount  in  16  unsigned deposit/withdraw amount
- language  in  1  display language (0 English, 1 alternate)
- balance  out  16  registered balance of the session account; 0 outside a session
- current_state  out  3  registered FSM state code

## Operation
- States: IDLE=0, AUTH=1, MENU=2, BALANCE=3, DEPOSIT=4, WITHDRAW=5, CHANGE_PIN=6, ERROR=7.
- Reset: state IDLE, balance 0, session cleared, all lock bits and fail counters 0. Account i gets PIN 1000+i (decimal) and balance 1000.
- IDLE: operation==0 stays. Nonzero operation: latch acc_num, pin and language, go AUTH.
- AUTH: locked account -> ERROR (no session). Latched PIN equals stored PIN -> clear that account's fail counter, open session, go MENU. Mismatch -> increment fail counter (2 bits, saturating), go ERROR. Counter reaching 3 sets the lock bit. Lock clears only on reset.
- MENU arming: an internal armed flag is cleared on entry from AUTH and on each dispatch. It is set in any MENU cycle with operation==0. When not armed, MENU stays and ignores operation.
- MENU dispatch when armed: 1->BALANCE, 2->DEPOSIT, 3->WITHDRAW, 4->CHANGE_PIN, 5->IDLE (close session, balance output 0). 0/6/7 stay MENU.
- BALANCE: no table change, return MENU.
- DEPOSIT: samples amount this cycle.
  - 17-bit sum of balance + amount > 65535 -> ERROR, balance unchanged.
  - Otherwise store the sum, return MENU.
- WITHDRAW: samples amount this cycle.
  - amount > balance -> ERROR, unchanged.
  - Otherwise store balance-amount, return MENU.
  - amount == balance is legal and results in 0.
- CHANGE_PIN: stored PIN <= Newpin, return MENU.
- ERROR: one cycle. Goes to MENU if a session is open (with armed cleared), else IDLE.
- balance output: registered. Equals the session account's stored balance (post-update) in MENU, BALANCE, DEPOSIT, WITHDRAW, CHANGE_PIN, and in ERROR with a session. Otherwise 0.
- language is latched per session. It has no effect on numeric outputs.

## Timing
- All state, table and outputs update on the rising clk edge. rst_n asserted mid-transaction aborts immediately and reinitialises the table.
- Login latency: operation nonzero sampled in IDLE at edge k gives AUTH after k and MENU after k+1.
- Transaction: dispatch sampled at edge m gives op state after m and MENU after m+1. The new balance is visible from edge m+1.
- Inputs are sampled only in the states listed. Changing acc_num mid-session has no effect.

## Test plan
- Reset -> current_state=0, balance=0. Login acct 3, pin 1003, op=1 -> states 1 then 2, balance=1000.
- In session, op 0 then op 2 with amount 250 -> DEPOSIT, then MENU, balance=1250. Holding op=2 does not repeat the deposit.
- Withdraw 1300 from 1250 -> ERROR then MENU, balance 1250. Withdraw 1250 -> balance 0.
- Deposit 65000 onto 1000 -> ERROR, balance unchanged at 1000.
- Change PIN to 4321, logout (op 5) -> IDLE, balance 0. Relogin with 1003 -> ERROR then IDLE. Relogin with 4321 -> MENU.
- Three wrong PINs on acct 7 -> third sets lock. Correct pin 1007 then -> ERROR. Pulse rst_n low -> login with 1007 succeeds.
